// File: rtl/mul_rr_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: datapath widths,
// default multiplier latency and the layout of the in-flight ownership tag.
package mul_rr_sched_pkg;

    localparam int MUL_A_W     = 32;
    localparam int MUL_P_W     = 64;
    localparam int OP_W        = 64;
    localparam int DEF_MUL_LAT = 6;

    // Four id bits cover the largest supported requester count (16).
    localparam int TAG_ID_W    = 4;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_rr_sched_if.sv
// Requester-side bus of the scheduler: per-requester valid/ready/operands and
// the broadcast product with its one-hot owner strobe.
interface mul_rr_sched_if
    import mul_rr_sched_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_op1;
    logic [NREQ*OP_W-1:0] req_op2;
    logic [NREQ-1:0]      resp_valid;
    logic [MUL_P_W-1:0]   resp_dst;

    modport master (
        output req_valid, req_op1, req_op2,
        input  req_ready, resp_valid, resp_dst
    );

    modport slave (
        input  req_valid, req_op1, req_op2,
        output req_ready, resp_valid, resp_dst
    );

endinterface

// File: rtl/mul_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// Shares one pipelined 32x32->64 multiplier between NREQ requesters, tracking the
// owner of every in-flight product with a tag pipeline matched to the multiplier.
module mul_rr_sched
    import mul_rr_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    mul_rr_sched_if.slave      req_if,
    output logic [MUL_A_W-1:0] mul_a,
    output logic [MUL_A_W-1:0] mul_b,
    input  logic [MUL_P_W-1:0] mul_p,
    output logic               idle,
    output logic [CNT_W-1:0]   issue_cnt
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [NREQ-1:0]    arb_req;
    logic [NREQ-1:0]    gnt;
    logic               transfer;
    logic [MUL_A_W-1:0] sel_op1;
    logic [MUL_A_W-1:0] sel_op2;
    tag_t               issue_tag;
    tag_t               tag_pipe [MUL_LAT];
    logic               any_vld;
    logic               unused_hi;

    // Masking requests during reset keeps req_ready low while rst is high.
    assign arb_req = rst ? '0 : req_if.req_valid;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req    (arb_req),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_if.req_ready = gnt;
    assign transfer         = |gnt;

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op1 = req_if.req_op1[OP_W*i +: MUL_A_W];
                sel_op2 = req_if.req_op2[OP_W*i +: MUL_A_W];
            end
        end
    end

    // Operand upper halves are architecturally ignored.
    assign unused_hi = ^{req_if.req_op1, req_if.req_op2};

    // issue_tag rides alongside mul_a/mul_b; the MUL_LAT-deep shift behind it then
    // lines the owner up with the product emerging on mul_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            issue_cnt <= '0;
            issue_tag <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            issue_tag   <= '{vld: transfer, id: TAG_ID_W'(gnt_id)};
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (transfer) begin
                ptr       <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                mul_a     <= sel_op1;
                mul_b     <= sel_op2;
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        any_vld = issue_tag.vld;
        for (int i = 0; i < MUL_LAT; i++) begin
            any_vld = any_vld | tag_pipe[i].vld;
        end
    end

    assign idle              = ~any_vld & ~|req_if.req_valid;
    assign req_if.resp_valid = tag_pipe[MUL_LAT-1].vld ? (NREQ'(1) << tag_pipe[MUL_LAT-1].id) : '0;
    assign req_if.resp_dst   = mul_p;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Self-checking bench for mul_rr_sched: behavioural multiplier, queue-based
// expectation model checked every cycle, plus directed scenarios with literal results.
module tb_mul_rr_sched;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 6;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [63:0]       mul_p;
    logic              idle;
    logic [CNT_W-1:0]  issue_cnt;

    mul_rr_sched_if #(.NREQ(NREQ)) bus ();

    mul_rr_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (bus),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .idle      (idle),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Multiplier IP stand-in: samples A/B every edge, product appears MUL_LAT edges later.
    logic [63:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        for (int i = MUL_LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
        mpipe[0] <= 64'(mul_a) * 64'(mul_b);
    end
    assign mul_p = mpipe[MUL_LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [63:0] prod;
    } exp_t;

    exp_t            q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc   = 0;
    bit              chk_en = 1'b0;
    int              m_ptr = 0;
    int              m_cnt = 0;
    int              m_j;
    int              m_id;
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rv;
    logic [63:0]     exp_p;
    bit              has_resp;
    logic [NREQ-1:0] last_gnt = '0;

    logic            r_valid [NREQ];
    logic [63:0]     r_op1   [NREQ];
    logic [63:0]     r_op2   [NREQ];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation model: grant = first valid at or above the model pointer; each
    // grant schedules its product 1+MUL_LAT cycles ahead; reset flushes everything.
    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            exp_rv   = '0;
            exp_p    = '0;
            has_resp = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv[q[0].id] = 1'b1;
                exp_p           = q[0].prod;
                has_resp        = 1'b1;
            end
            exp_gnt = '0;
            m_id    = 0;
            if (!rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_j = (m_ptr + k) % NREQ;
                    if (bus.req_valid[m_j] && exp_gnt == '0) begin
                        exp_gnt[m_j] = 1'b1;
                        m_id         = m_j;
                    end
                end
            end
            checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
            checkOutput("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
            if (has_resp) checkOutput("resp_dst", bus.resp_dst, exp_p);
            checkOutput("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
            checkOutput("idle", 64'(idle), 64'(q.size() == 0 && bus.req_valid == '0));
            last_gnt = exp_gnt;
            if (rst) begin
                q.delete();
                m_ptr = 0;
                m_cnt = 0;
            end else if (exp_gnt != '0) begin
                q.push_back('{due: cyc + 1 + MUL_LAT, id: m_id,
                              prod: 64'(bus.req_op1[64*m_id +: 32]) * 64'(bus.req_op2[64*m_id +: 32])});
                m_ptr = (m_id + 1) % NREQ;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]          = r_valid[i];
            bus.req_op1[64*i +: 64]   = r_op1[i];
            bus.req_op2[64*i +: 64]   = r_op2[i];
        end
    endtask

    // Advance to just after the next edge and retire requests transferred on it.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (last_gnt[i]) r_valid[i] = 1'b0;
        pack();
    endtask

    task automatic raise(input int i, input logic [63:0] a, input logic [63:0] b);
        r_valid[i] = 1'b1;
        r_op1[i]   = a;
        r_op2[i]   = b;
        pack();
    endtask

    function automatic logic [63:0] randOp();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(3) == 0) v[31:0] = 32'hFFFF_FFFF;
        return v;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        pack();
        step();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int p_raise, input int p_rst);
        step();
        rst = ($urandom_range(999) < p_rst);
        for (int i = 0; i < NREQ; i++)
            if (!r_valid[i] && $urandom_range(99) < p_raise) raise(i, randOp(), randOp());
        pack();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            r_valid[i] = 1'b0;
            r_op1[i]   = '0;
            r_op2[i]   = '0;
        end
        pack();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        doReset();

        $display("[TB] single requester");
        raise(0, 64'd3, 64'd5);
        @(negedge clk);
        checkOutput("t1_ready", 64'(bus.req_ready), 64'h1);
        step();
        repeat (7) @(negedge clk);
        checkOutput("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
        checkOutput("t1_resp_dst", bus.resp_dst, 64'd15);
        @(negedge clk);
        checkOutput("t1_issue_cnt", 64'(issue_cnt), 64'd1);
        checkOutput("t1_idle", 64'(idle), 64'd1);
        step();

        $display("[TB] upper bits ignored, max operands");
        raise(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF);
        @(negedge clk);
        step();
        repeat (7) @(negedge clk);
        checkOutput("t3_resp_dst", bus.resp_dst, 64'hFFFF_FFFE_0000_0001);
        step();

        $display("[TB] all requesters continuously valid");
        doReset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) if (!r_valid[i]) raise(i, randOp(), randOp());
            @(negedge clk);
            checkOutput("t2_rr_grant", 64'(bus.req_ready), 64'(1) << (k % NREQ));
            step();
        end
        repeat (14) step();

        $display("[TB] pointer fairness");
        doReset();
        raise(2, 64'd2, 64'd2);
        @(negedge clk);
        checkOutput("t4_first", 64'(bus.req_ready), 64'b0100);
        step();
        raise(1, 64'd4, 64'd4);
        raise(3, 64'd6, 64'd6);
        @(negedge clk);
        checkOutput("t4_req3", 64'(bus.req_ready), 64'b1000);
        step();
        @(negedge clk);
        checkOutput("t4_req1", 64'(bus.req_ready), 64'b0010);
        repeat (10) step();

        $display("[TB] reset mid-flight");
        doReset();
        raise(0, 64'd11, 64'd12);
        raise(1, 64'd13, 64'd14);
        raise(2, 64'd15, 64'd16);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        raise(1, 64'd7, 64'd9);
        raise(3, 64'd8, 64'd8);
        @(negedge clk);
        checkOutput("t5_issue_cnt", 64'(issue_cnt), 64'd0);
        checkOutput("t5_ptr_reset", 64'(bus.req_ready), 64'b0010);
        step();
        repeat (7) @(negedge clk);
        checkOutput("t5_resp_valid", 64'(bus.resp_valid), 64'b0010);
        checkOutput("t5_resp_dst", bus.resp_dst, 64'd63);
        repeat (4) step();

        $display("[TB] counter wrap");
        doReset();
        for (int k = 0; k < 17; k++) begin
            if (!r_valid[0]) raise(0, randOp(), randOp());
            @(negedge clk);
            step();
        end
        @(negedge clk);
        checkOutput("t6_cnt_wrap", 64'(issue_cnt), 64'd1);
        repeat (10) step();

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) applyStimulus((n / 200) * 25 + 15, 6);
        rst = 1'b0;
        pack();
        repeat (20) applyStimulus(0, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
